// File: rtl/s2mm_cmd_ctrl.sv
// S2MM command sequencer: turns capture write requests into 72-bit DataMover
// commands with rolling tags, retires statuses in order and latches the first error.
module s2mm_cmd_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BTT_W       = 23,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              s_axi_clk,
  input  logic              s_axi_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BTT_W-1:0]  req_btt,
  output logic [71:0]       m_axis_cmd_tdata,
  output logic              m_axis_cmd_tvalid,
  input  logic              m_axis_cmd_tready,
  input  logic [7:0]        s_axis_sts_tdata,
  input  logic              s_axis_sts_tvalid,
  input  logic              s_axis_sts_tkeep,
  input  logic              s_axis_sts_tlast,
  output logic              s_axis_sts_tready,
  output logic              done,
  output logic [3:0]        done_tag,
  output logic              done_ok,
  output logic [3:0]        outstanding,
  output logic              busy,
  output logic [2:0]        err_code,
  input  logic              err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]    state;
  logic [3:0]    next_tag;
  logic [3:0]    exp_tag;
  logic [TW-1:0] timer;
  logic [71:0]   cmd;
  logic          accept;
  logic          cmd_hs;
  logic          beat;
  logic          retire;
  logic          sts_ok;
  logic          timeout_hit;
  logic [2:0]    new_err;
  logic          unused_sts;

  // Every status beat is a whole record, so keep/last carry no information.
  assign unused_sts = s_axis_sts_tkeep ^ s_axis_sts_tlast;

  // While in IDLE no command is pending, so the gate reduces to outstanding alone.
  assign req_ready         = !s_axi_reset && (state == S_IDLE) && (outstanding < 4'(MAX_OUT));
  assign accept            = req_valid && req_ready;
  assign m_axis_cmd_tvalid = (state == S_ISSUE);
  assign m_axis_cmd_tdata  = cmd;
  assign cmd_hs            = m_axis_cmd_tvalid && m_axis_cmd_tready;
  assign s_axis_sts_tready = !s_axi_reset;
  assign beat              = s_axis_sts_tvalid && s_axis_sts_tready;
  assign retire            = beat && (outstanding != 4'd0);
  assign sts_ok            = s_axis_sts_tdata[7] && (s_axis_sts_tdata[6:4] == 3'b000);
  assign timeout_hit       = (timer == TW'(TIMEOUT_CYC));
  assign busy              = (outstanding != 4'd0) || m_axis_cmd_tvalid;

  // Tag mismatch (including a stray beat with nothing in flight) outranks a bad status.
  always_comb begin
    new_err = 3'd0;
    if (beat && (!retire || s_axis_sts_tdata[3:0] != exp_tag)) new_err = 3'd2;
    else if (retire && !sts_ok)                                new_err = 3'd1;
    else if (timeout_hit)                                      new_err = 3'd3;
    else if (accept && req_btt == '0)                          new_err = 3'd4;
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      state       <= S_IDLE;
      next_tag    <= 4'd0;
      exp_tag     <= 4'd0;
      timer       <= '0;
      cmd         <= '0;
      outstanding <= 4'd0;
      done        <= 1'b0;
      done_tag    <= 4'd0;
      done_ok     <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      if (accept && req_btt != '0)
        cmd <= {4'h0, next_tag, 32'(req_addr), 8'h40, 1'b1, 23'(req_btt)};
      if (cmd_hs) next_tag <= next_tag + 4'd1;

      case ({cmd_hs, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase

      done <= retire;
      if (retire) begin
        exp_tag  <= exp_tag + 4'd1;
        done_tag <= s_axis_sts_tdata[3:0];
        done_ok  <= sts_ok;
      end

      if (beat || outstanding == 4'd0) timer <= '0;
      else if (!timeout_hit)           timer <= timer + TW'(1);

      // A clear in the same cycle as a fresh error lets the fresh error through.
      if (new_err != 3'd0 && (err_code == 3'd0 || err_clr)) err_code <= new_err;
      else if (err_clr)                                     err_code <= 3'd0;

      if (new_err != 3'd0) state <= S_HALT;
      else begin
        case (state)
          S_IDLE:  if (accept)  state <= S_ISSUE;
          S_ISSUE: if (cmd_hs)  state <= S_IDLE;
          S_HALT:  if (err_clr) state <= S_IDLE;
          default:              state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
